if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the ID stage, which holds the opcode/funct decode and register read.
- Owns the PC and selects the next PC from the 2-bit PC-source select. It drives a ready-handshaked instruction-memory port and produces the IF/ID pipeline register.
- Absorbs stalls from the hazard unit, flushes from the controller, and variable instruction-memory latency, without losing or duplicating instructions.

---
 rtl/if_fetch_stage.sv | 200 ++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC ownership, next-PC select, ready-handshaked imem port, IF/ID register.
// Optional performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_HOLD     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_hold_inst;
  logic [31:0] r_redir_pc;
  logic [31:0] r_ifid_inst;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic [31:0] w_target;
  logic        w_redirect;
  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;
  logic [31:0] w_hold_next;
  logic [31:0] w_redir_next;
  logic        w_bubble_req;
  logic        w_ld;
  logic [31:0] w_ld_inst;
  logic [31:0] w_ld_pc4;
  logic        w_ld_valid;

  always_comb begin
    unique case (pcsrc)
      2'b01:   w_target = branch_target;
      2'b10:   w_target = jump_target;
      2'b11:   w_target = jr_target;
      default: w_target = r_pc + 32'd4;
    endcase
  end

  assign w_redirect = (pcsrc != 2'b00);
  assign w_pc4      = r_pc + 32'd4;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold_next  = r_hold_inst;
    w_redir_next = r_redir_pc;
    w_bubble_req = 1'b0;
    w_ld         = 1'b0;
    w_ld_inst    = NOP_INST;
    w_ld_pc4     = '0;
    w_ld_valid   = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          if (w_redirect) begin
            w_pc_next    = w_target;
            w_bubble_req = 1'b1;
          end else if (!stall) begin
            w_ld       = 1'b1;
            w_ld_inst  = imem_rdata;
            w_ld_pc4   = w_pc4;
            w_ld_valid = 1'b1;
            w_pc_next  = w_pc4;
          end else begin
            w_hold_next  = imem_rdata;
            w_state_next = S_HOLD;
          end
        end else begin
          if (w_redirect) begin
            w_redir_next = w_target;
            w_state_next = S_REDIRECT;
          end
          w_bubble_req = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = S_FETCH;
          w_bubble_req = 1'b1;
        end else if (!stall) begin
          w_ld         = 1'b1;
          w_ld_inst    = r_hold_inst;
          w_ld_pc4     = w_pc4;
          w_ld_valid   = 1'b1;
          w_pc_next    = w_pc4;
          w_state_next = S_FETCH;
        end
      end
      S_REDIRECT: begin
        // A redirect arriving on the completing cycle still wins over the stored target.
        if (w_redirect) begin
          w_redir_next = w_target;
        end
        if (imem_ready) begin
          w_pc_next    = w_redir_next;
          w_state_next = S_FETCH;
        end
        w_bubble_req = 1'b1;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase

    if (w_bubble_req && !stall) begin
      w_ld       = 1'b1;
      w_ld_inst  = NOP_INST;
      w_ld_pc4   = '0;
      w_ld_valid = 1'b0;
    end

    // Flush squashes IF/ID only; pc, state and the hold buffer follow the cases above.
    if (flush) begin
      w_ld       = 1'b1;
      w_ld_inst  = NOP_INST;
      w_ld_pc4   = '0;
      w_ld_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_hold_inst  <= '0;
      r_redir_pc   <= '0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_hold_inst <= w_hold_next;
      r_redir_pc  <= w_redir_next;
      if (w_ld) begin
        r_ifid_inst  <= w_ld_inst;
        r_ifid_pc4   <= w_ld_pc4;
        r_ifid_valid <= w_ld_valid;
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_ld && w_ld_valid) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_ld && !w_ld_valid && !stall) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`endif

  assign imem_req   = (r_state != S_HOLD);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ifid_inst  = r_ifid_inst;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random traffic, checked against a
// behavioural model of the fetch stage (held word, pending redirect, IF/ID contents).
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ready;
  logic [1:0]  pcsrc;
  logic [31:0] bt, jt, jrt, rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, ifid_inst, ifid_pc4;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .branch_target(bt), .jump_target(jt), .jr_target(jrt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(rdata), .imem_ready(ready),
    .pc(pc), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
`ifdef IF_FETCH_PERF_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .ifid_valid(ifid_valid)
  );

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;
  logic rand_data = 1'b0;

  // Model state: fetch address, a captured-but-undelivered word, a pending redirect target.
  logic [31:0] m_pc, m_held, m_rtgt, m_inst, m_pc4, m_fcnt, m_bcnt;
  logic        m_holding, m_pending, m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_step();
    logic [31:0] tgt, li, lp;
    logic        redir;
    int          ld;
    li = '0; lp = '0; ld = 0;
    if (rst) begin
      m_pc = RST_PC; m_held = '0; m_rtgt = '0; m_holding = 1'b0; m_pending = 1'b0;
      m_inst = NOP; m_pc4 = '0; m_valid = 1'b0; m_fcnt = '0; m_bcnt = '0;
      return;
    end
    tgt   = (pcsrc == 2'd1) ? bt : (pcsrc == 2'd2) ? jt : jrt;
    redir = (pcsrc != 2'd0);
    if (m_holding) begin
      if (redir) begin m_pc = tgt; m_holding = 1'b0; ld = stall ? 0 : 1; end
      else if (!stall) begin ld = 2; li = m_held; lp = m_pc + 4; m_pc = m_pc + 4; m_holding = 1'b0; end
    end else if (m_pending) begin
      if (redir) m_rtgt = tgt;
      if (ready) begin m_pc = m_rtgt; m_pending = 1'b0; end
      ld = stall ? 0 : 1;
    end else if (ready) begin
      if (redir) begin m_pc = tgt; ld = stall ? 0 : 1; end
      else if (!stall) begin ld = 2; li = rdata; lp = m_pc + 4; m_pc = m_pc + 4; end
      else begin m_held = rdata; m_holding = 1'b1; end
    end else begin
      if (redir) begin m_rtgt = tgt; m_pending = 1'b1; end
      ld = stall ? 0 : 1;
    end
    if (flush) ld = 1;
    if (ld == 1) begin
      m_inst = NOP; m_pc4 = '0; m_valid = 1'b0;
      if (!stall) m_bcnt = m_bcnt + 1;
    end else if (ld == 2) begin
      m_inst = li; m_pc4 = lp; m_valid = 1'b1; m_fcnt = m_fcnt + 1;
    end
  endfunction

  task automatic check_outputs();
    chk("imem_req",   {31'd0, imem_req},   {31'd0, !m_holding});
    chk("imem_addr",  imem_addr,           m_pc);
    chk("pc",         pc,                  m_pc);
    chk("ifid_inst",  ifid_inst,           m_inst);
    chk("ifid_pc4",   ifid_pc4,            m_pc4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
`ifdef IF_FETCH_PERF_EN
    chk("fetch_count",  fetch_count,  m_fcnt);
    chk("bubble_count", bubble_count, m_bcnt);
`endif
  endtask

  // One clock: inputs applied away from the edge, model advanced at the edge, outputs checked at negedge.
  task automatic cyc(input logic r, input logic s, input logic f, input logic [1:0] src,
                     input logic rdy, input logic [31:0] tgt);
    rst = r; stall = s; flush = f; pcsrc = src; ready = rdy;
    bt = $urandom; jt = $urandom; jrt = $urandom;
    if (src == 2'd1) bt = tgt;
    if (src == 2'd2) jt = tgt;
    if (src == 2'd3) jrt = tgt;
    rdata = rand_data ? $urandom : (m_pc + 32'h1000);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 2'd0; ready = 1'b0;
    bt = '0; jt = '0; jrt = '0; rdata = '0;
    m_pc = '0; m_held = '0; m_rtgt = '0; m_inst = '0; m_pc4 = '0; m_fcnt = '0; m_bcnt = '0;
    m_holding = 1'b0; m_pending = 1'b0; m_valid = 1'b0;
    @(negedge clk);

    cyc(1, 0, 0, 2'd0, 1, '0);
    chk("reset_pc", pc, RST_PC);
    chk("reset_req", {31'd0, imem_req}, 32'd1);

    // Straight line
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("line_inst0", ifid_inst, 32'h1000);
    chk("line_pc4_0", ifid_pc4, 32'd4);
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("line_inst1", ifid_inst, 32'h1004);

    // Memory latency at pc=8
    repeat (3) cyc(0, 0, 0, 2'd0, 0, '0);
    chk("lat_addr", imem_addr, 32'd8);
    chk("lat_bubble", {31'd0, ifid_valid}, 32'd0);
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("lat_inst", ifid_inst, 32'h1008);
    chk("lat_pc", pc, 32'd12);

    // Redirect while request pending at pc=12
    cyc(0, 0, 0, 2'd1, 0, 32'h40);
    cyc(0, 0, 0, 2'd0, 0, '0);
    chk("redir_addr_stable", imem_addr, 32'd12);
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("redir_pc", pc, 32'h40);
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("redir_inst", ifid_inst, 32'h1040);

    // Stall on capture at pc=0x44
    cyc(0, 1, 0, 2'd0, 1, '0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_ifid", ifid_inst, 32'h1040);
    cyc(0, 1, 0, 2'd0, 1, '0);
    cyc(0, 0, 0, 2'd0, 0, '0);
    chk("hold_release", ifid_inst, 32'h1044);
    chk("hold_pc", pc, 32'h48);

    // Flush during stall
    cyc(0, 1, 1, 2'd0, 0, '0);
    chk("flush_inst", ifid_inst, NOP);
    chk("flush_pc", pc, 32'h48);

    // Reset while in REDIRECT
    cyc(0, 0, 0, 2'd2, 0, 32'h80);
    cyc(1, 0, 0, 2'd0, 0, '0);
    chk("rst_mid_pc", pc, RST_PC);
    chk("rst_mid_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_FETCH_PERF_EN
    chk("rst_mid_fcnt", fetch_count, 32'd0);
    chk("rst_mid_bcnt", bubble_count, 32'd0);
`endif
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("rst_mid_inst", ifid_inst, 32'h1000);

    // PC wrap at the top of the address space
    cyc(0, 0, 0, 2'd3, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 2'd0, 1, '0);
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_pc4", ifid_pc4, 32'd0);
    chk("wrap_inst", ifid_inst, 32'h0000_0FFC);

    // Random traffic
    rand_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0),
          (($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0),
          ($urandom_range(0, 2) != 0),
          $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
